cga_palette_ctrl: RTL and testbench

CGA_PALETTE_CTRL -- requirements
Module: cga_palette_ctrl

---
 rtl/cga_palette_pkg.sv | 36 +++
 rtl/cga_palette_lut.sv | 47 ++++
 rtl/cga_palette_ctrl.sv | 116 +++++++++++
 tb/tb_cga_palette_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cga_palette_pkg.sv
// Shared definitions for the CGA palette controller: host phase encoding,
// register map and the default 16-colour palette.
package cga_palette_pkg;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    localparam logic [1:0] ADDR_WIDX  = 2'd0;
    localparam logic [1:0] ADDR_WDATA = 2'd1;
    localparam logic [1:0] ADDR_RIDX  = 2'd2;
    localparam logic [1:0] ADDR_RDATA = 2'd3;

    // Entries packed {R, G, B}; index 6 is brown (green halved), 8-F add the intensity base.
    localparam logic [17:0] CGA_PALETTE [16] = '{
        {6'd0,  6'd0,  6'd0 },
        {6'd0,  6'd0,  6'd42},
        {6'd0,  6'd42, 6'd0 },
        {6'd0,  6'd42, 6'd42},
        {6'd42, 6'd0,  6'd0 },
        {6'd42, 6'd0,  6'd42},
        {6'd42, 6'd21, 6'd0 },
        {6'd42, 6'd42, 6'd42},
        {6'd21, 6'd21, 6'd21},
        {6'd21, 6'd21, 6'd63},
        {6'd21, 6'd63, 6'd21},
        {6'd21, 6'd63, 6'd63},
        {6'd63, 6'd21, 6'd21},
        {6'd63, 6'd21, 6'd63},
        {6'd63, 6'd63, 6'd21},
        {6'd63, 6'd63, 6'd63}
    };

endpackage

// File: rtl/cga_palette_lut.sv
// Palette storage with a registered pixel lookup and blank mux, plus a
// combinational host-side read port.
import cga_palette_pkg::*;

module cga_palette_lut #(
    parameter int RESET_PALETTE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  video,
    input  logic        blank,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [17:0] wdata,
    input  logic [3:0]  raddr,
    output logic [17:0] rentry,
    output logic [5:0]  red,
    output logic [5:0]  green,
    output logic [5:0]  blue
);

    logic [17:0] palette [16];

    // NOTE: the palette is flop-based and explicitly reset because the reset
    // contents are architecturally visible; a RAM macro could not do this.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= (RESET_PALETTE != 0) ? CGA_PALETTE[i] : 18'd0;
            end
            {red, green, blue} <= '0;
        end else begin
            if (we) begin
                palette[waddr] <= wdata;
            end
            // Lookup samples the pre-commit entry, so a same-cycle write shows up one cycle later.
            if (blank) begin
                {red, green, blue} <= '0;
            end else begin
                {red, green, blue} <= palette[video];
            end
        end
    end

    assign rentry = palette[raddr];

endmodule

// File: rtl/cga_palette_ctrl.sv
// CGA palette controller: host register interface with three-phase write and
// read sequencers in front of the palette lookup.
import cga_palette_pkg::*;

module cga_palette_ctrl #(
    parameter int RESET_PALETTE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] video,
    input  logic       blank,
    input  logic [1:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic [5:0] red,
    output logic [5:0] green,
    output logic [5:0] blue
);

    phase_t      wphase, rphase;
    logic [3:0]  windex, rindex;
    logic [5:0]  hold_r, hold_g;
    logic        commit;
    logic [17:0] rentry;
    logic [5:0]  rd_comp;

    // NOTE: always_comb outputs get a default first so no path can infer a latch.
    always_comb begin
        commit  = bus_wr && (bus_addr == ADDR_WDATA) && (wphase == PH_B);
        rd_comp = rentry[5:0];
        case (rphase)
            PH_R:    rd_comp = rentry[17:12];
            PH_G:    rd_comp = rentry[11:6];
            default: rd_comp = rentry[5:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch sees pre-edge values of windex/phase regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wphase   <= PH_R;
            rphase   <= PH_R;
            windex   <= '0;
            rindex   <= '0;
            hold_r   <= '0;
            hold_g   <= '0;
            bus_dout <= '0;
        end else if (bus_wr) begin
            case (bus_addr)
                ADDR_WIDX: begin
                    windex <= bus_din[3:0];
                    wphase <= PH_R;
                end
                ADDR_WDATA: begin
                    case (wphase)
                        PH_R: begin
                            hold_r <= bus_din[5:0];
                            wphase <= PH_G;
                        end
                        PH_G: begin
                            hold_g <= bus_din[5:0];
                            wphase <= PH_B;
                        end
                        default: begin
                            windex <= windex + 4'd1;
                            wphase <= PH_R;
                        end
                    endcase
                end
                ADDR_RIDX: begin
                    rindex <= bus_din[3:0];
                    rphase <= PH_R;
                end
                default: ;
            endcase
        end else if (bus_rd) begin
            case (bus_addr)
                ADDR_WIDX:  bus_dout <= {4'b0000, windex};
                ADDR_WDATA: bus_dout <= {6'b000000, wphase};
                ADDR_RIDX:  bus_dout <= {4'b0000, rindex};
                default: begin
                    bus_dout <= {2'b00, rd_comp};
                    case (rphase)
                        PH_R: rphase <= PH_G;
                        PH_G: rphase <= PH_B;
                        default: begin
                            rphase <= PH_R;
                            rindex <= rindex + 4'd1;
                        end
                    endcase
                end
            endcase
        end
    end

    cga_palette_lut #(
        .RESET_PALETTE(RESET_PALETTE)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .video   (video),
        .blank   (blank),
        .we      (commit),
        .waddr   (windex),
        .wdata   ({hold_r, hold_g, bus_din[5:0]}),
        .raddr   (rindex),
        .rentry  (rentry),
        .red     (red),
        .green   (green),
        .blue    (blue)
    );

endmodule

// File: tb/tb_cga_palette_ctrl.sv
// Scoreboard bench for cga_palette_ctrl: a behavioural palette model predicts
// pixel and bus_dout each cycle; a monitor compares after every clock edge.
module tb_cga_palette_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] video = '0;
    logic       blank = 1'b0;
    logic [1:0] bus_addr = '0;
    logic       bus_wr = 1'b0;
    logic       bus_rd = 1'b0;
    logic [7:0] bus_din = '0;
    logic [7:0] bus_dout;
    logic [5:0] red, green, blue;

    cga_palette_ctrl #(.RESET_PALETTE(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .video    (video),
        .blank    (blank),
        .bus_addr (bus_addr),
        .bus_wr   (bus_wr),
        .bus_rd   (bus_rd),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] pix;
        logic [7:0]  dout;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int m_r[16], m_g[16], m_b[16];
    int m_widx, m_wstep, m_hr, m_hg;
    int m_ridx, m_rstep, m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            int lo, hi;
            lo = (i < 8) ? 0 : 21;
            hi = (i < 8) ? 42 : 63;
            m_r[i] = ((i & 4) != 0) ? hi : lo;
            m_g[i] = ((i & 2) != 0) ? hi : lo;
            m_b[i] = ((i & 1) != 0) ? hi : lo;
        end
        m_g[6] = 21;
        m_widx = 0; m_wstep = 0; m_hr = 0; m_hg = 0;
        m_ridx = 0; m_rstep = 0; m_dout = 0;
    endtask

    function automatic logic [17:0] entry(input int i);
        logic [5:0] r, g, b;
        r = 6'(m_r[i]); g = 6'(m_g[i]); b = 6'(m_b[i]);
        return {r, g, b};
    endfunction

    // Drive one cycle of inputs at the falling edge and predict the post-edge outputs.
    task automatic step(input logic rst_n, input logic [3:0] vid, input logic blk,
                        input logic [1:0] a, input logic wr, input logic rd, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset_n = rst_n; video = vid; blank = blk;
        bus_addr = a; bus_wr = wr; bus_rd = rd; bus_din = d;
        if (!rst_n) begin
            model_reset();
            e.pix = '0;
        end else begin
            e.pix = blk ? 18'd0 : entry(int'(vid));
            if (wr) begin
                case (a)
                    2'd0: begin m_widx = int'(d[3:0]); m_wstep = 0; end
                    2'd1: begin
                        if (m_wstep == 0) begin m_hr = int'(d[5:0]); m_wstep = 1; end
                        else if (m_wstep == 1) begin m_hg = int'(d[5:0]); m_wstep = 2; end
                        else begin
                            m_r[m_widx] = m_hr; m_g[m_widx] = m_hg; m_b[m_widx] = int'(d[5:0]);
                            m_widx = (m_widx + 1) % 16; m_wstep = 0;
                        end
                    end
                    2'd2: begin m_ridx = int'(d[3:0]); m_rstep = 0; end
                    default: ;
                endcase
            end else if (rd) begin
                case (a)
                    2'd0: m_dout = m_widx;
                    2'd1: m_dout = m_wstep;
                    2'd2: m_dout = m_ridx;
                    default: begin
                        m_dout = (m_rstep == 0) ? m_r[m_ridx] : (m_rstep == 1) ? m_g[m_ridx] : m_b[m_ridx];
                        m_rstep = m_rstep + 1;
                        if (m_rstep == 3) begin m_rstep = 0; m_ridx = (m_ridx + 1) % 16; end
                    end
                endcase
            end
        end
        e.dout = 8'(m_dout);
        q.push_back(e);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        step(1'b1, 4'($urandom_range(15)), 1'b0, a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(1'b1, 4'($urandom_range(15)), 1'b0, a, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic pix(input logic [3:0] v, input logic b);
        step(1'b1, v, b, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: every item pushed at a falling edge is due right after the next rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("pixel", {red, green, blue}, e.pix);
                check("bus_dout", bus_dout, e.dout);
            end
        end
    end

    initial begin
        model_reset();
        step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);

        // Default palette lookups
        pix(4'd6, 1'b0); pix(4'hF, 1'b0); pix(4'd8, 1'b0); pix(4'd6, 1'b1);

        // Write entry 3, then auto-increment into entry 4
        wr_reg(2'd0, 8'd3);
        wr_reg(2'd1, 8'd10); wr_reg(2'd1, 8'd20); wr_reg(2'd1, 8'd30);
        pix(4'd3, 1'b0);
        wr_reg(2'd1, 8'd1); wr_reg(2'd1, 8'd2); wr_reg(2'd1, 8'd3);
        pix(4'd4, 1'b0); pix(4'd3, 1'b0);

        // Index wrap 15 -> 0 -> 1
        wr_reg(2'd0, 8'h0F);
        for (int i = 0; i < 9; i++) wr_reg(2'd1, 8'(7 * i + 5));
        pix(4'hF, 1'b0); pix(4'd0, 1'b0); pix(4'd1, 1'b0);
        rd_reg(2'd0);

        // Abandoned partial write is discarded
        wr_reg(2'd0, 8'd5);
        wr_reg(2'd1, 8'd63); pix(4'd5, 1'b0);
        wr_reg(2'd1, 8'd63); rd_reg(2'd1); pix(4'd5, 1'b0);
        wr_reg(2'd0, 8'd5); rd_reg(2'd1);
        wr_reg(2'd1, 8'd1); wr_reg(2'd1, 8'd2); wr_reg(2'd1, 8'd3);
        pix(4'd5, 1'b0);

        // Commit while looking up the same entry
        wr_reg(2'd0, 8'd2);
        step(1'b1, 4'd2, 1'b0, 2'd1, 1'b1, 1'b0, 8'd11);
        step(1'b1, 4'd2, 1'b0, 2'd1, 1'b1, 1'b0, 8'd22);
        step(1'b1, 4'd2, 1'b0, 2'd1, 1'b1, 1'b0, 8'd33);
        pix(4'd2, 1'b0); pix(4'd2, 1'b1);

        // Readback with auto-increment, then simultaneous write and read
        wr_reg(2'd2, 8'd6);
        rd_reg(2'd3); rd_reg(2'd3); rd_reg(2'd3); rd_reg(2'd3);
        rd_reg(2'd2);
        step(1'b1, 4'd7, 1'b0, 2'd2, 1'b1, 1'b1, 8'd9);
        pix(4'd0, 1'b0); rd_reg(2'd2);

        // Reset mid-sequence abandons the partial write
        wr_reg(2'd0, 8'd9); wr_reg(2'd1, 8'd1); wr_reg(2'd1, 8'd1);
        step(1'b0, 4'd9, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1);
        pix(4'd9, 1'b0); rd_reg(2'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic rst_n, wr, rd;
            rst_n = ($urandom_range(99) != 0);
            wr = ($urandom_range(2) == 0);
            rd = ($urandom_range(2) == 0);
            step(rst_n, 4'($urandom_range(15)), ($urandom_range(4) == 0),
                 2'($urandom_range(3)), wr, rd, 8'($urandom_range(255)));
        end

        pix(4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
